// File: rtl/data_mem_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared types and helpers for the data_mem_master load/store block.
//   mem_op_e      : 3-bit memory operation encoding (loads 0..4, stores 5..7)
//   mstate_e      : initiator FSM states, valued from legacy state constants
//   CHIP_/WRITE_* : RAM control levels
//   is_store()    : true for SB/SH/SW
//   is_misaligned : half op on odd address, word op on non-word address
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } mstate_e;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  function automatic logic is_store(input mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
    logic mis;
    case (op)
      LH, LHU, SH: mis = a[0];
      LW, SW:      mis = (a != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_master_if.sv
// -----------------------------------------------------------------------------
// data_mem_master_if: MEM-stage request/response handshake plus RAM bus.
//   Signal names keep the original top-level port names.
//   modport master : view of data_mem_master (drives RAM, consumes requests)
//   modport slave  : view of the environment (pipeline + RAM)
// -----------------------------------------------------------------------------
interface data_mem_master_if
  import mem_pkg::*;
#(
  parameter int N_MEM_ADDR = 32,
  parameter int N_MEM_DATA = 32
);
  logic                  i_req_valid;
  logic                  o_req_ready;
  mem_op_e               i_req_op;
  logic [N_MEM_ADDR-1:0] i_req_addr;
  logic [N_MEM_DATA-1:0] i_req_wdata;
  logic                  o_rsp_valid;
  logic [N_MEM_DATA-1:0] o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_stall;
  logic                  o_mem_ce;
  logic                  o_mem_we;
  logic [3:0]            o_mem_sel;
  logic [N_MEM_ADDR-1:0] o_mem_addr;
  logic [N_MEM_DATA-1:0] o_mem_data;
  logic [N_MEM_DATA-1:0] i_mem_data;

  modport master (
    input  i_req_valid, i_req_op, i_req_addr, i_req_wdata, i_mem_data,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_stall,
    output o_mem_ce, o_mem_we, o_mem_sel, o_mem_addr, o_mem_data
  );

  modport slave (
    output i_req_valid, i_req_op, i_req_addr, i_req_wdata, i_mem_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_stall,
    input  o_mem_ce, o_mem_we, o_mem_sel, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/data_mem_master_load_fmt.sv
// -----------------------------------------------------------------------------
// mem_load_fmt: combinational load-data formatter.
//   op_i   : memory op
//   addr_i : byte offset within the word
//   raw_i  : raw RAM word (big-endian: offset 0 is raw_i[31:24])
//   data_o : selected byte/half, sign- or zero-extended; LW passes raw_i;
//            stores yield 0
// -----------------------------------------------------------------------------
module mem_load_fmt
  import mem_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (addr_i)
      2'd0:    byte_v = raw_i[31:24];
      2'd1:    byte_v = raw_i[23:16];
      2'd2:    byte_v = raw_i[15:8];
      default: byte_v = raw_i[7:0];
    endcase
    half_v = addr_i[1] ? raw_i[15:0] : raw_i[31:16];

    data_o = '0;
    case (op_i)
      LB:      data_o = {{24{byte_v[7]}}, byte_v};
      LBU:     data_o = {24'h000000, byte_v};
      LH:      data_o = {{16{half_v[15]}}, half_v};
      LHU:     data_o = {16'h0000, half_v};
      LW:      data_o = raw_i;
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/data_mem_master.sv
// -----------------------------------------------------------------------------
// data_mem_master: load/store initiator between the MEM stage and data RAM.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (master)   : request handshake (i_req_*/o_req_ready), one-cycle
//                    response (o_rsp_*), pipeline stall (o_stall) and the
//                    RAM bus (o_mem_*, i_mem_data, combinational read)
// A request is latched in IDLE, the RAM is held for WAIT_CYCLES+1 cycles in
// ACCESS, then a single RESP cycle presents the formatted result. Misaligned
// requests skip ACCESS and respond with err=1 the following cycle.
// -----------------------------------------------------------------------------
module data_mem_master
  import mem_pkg::*;
#(
  parameter int N_MEM_ADDR  = 32,
  parameter int N_MEM_DATA  = 32,
  parameter int WAIT_CYCLES = 0
)(
  input logic               i_clk,
  input logic               i_rst_n,
  data_mem_master_if.master bus
);
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  mstate_e               state_q, state_d;
  mem_op_e               op_q, op_d;
  logic [N_MEM_ADDR-1:0] addr_q, addr_d;
  logic [N_MEM_DATA-1:0] wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [N_MEM_DATA-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] fmt_data;
  logic [3:0]  sel_w;
  logic [31:0] wdat_w;

  mem_load_fmt u_fmt (
    .op_i   (op_q),
    .addr_i (addr_q[1:0]),
    .raw_i  (bus.i_mem_data),
    .data_o (fmt_data)
  );

  // Byte lanes and replicated store data for the latched op.
  always_comb begin
    sel_w  = 4'b1111;
    wdat_w = wdata_q;
    case (op_q)
      LB, LBU, SB: begin
        sel_w  = 4'b1000 >> addr_q[1:0];
        wdat_w = {4{wdata_q[7:0]}};
      end
      LH, LHU, SH: begin
        sel_w  = addr_q[1] ? 4'b0011 : 4'b1100;
        wdat_w = {2{wdata_q[15:0]}};
      end
      default: begin
        sel_w  = 4'b1111;
        wdat_w = wdata_q;
      end
    endcase
    if (!is_store(op_q)) wdat_w = '0;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req_valid) begin
          op_d    = bus.i_req_op;
          addr_d  = bus.i_req_addr;
          wdata_d = bus.i_req_wdata;
          if (is_misaligned(bus.i_req_op, bus.i_req_addr[1:0])) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LIM) begin
          rdata_d = is_store(op_q) ? '0 : fmt_data;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= LB;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM outputs decode from state so an async reset clears them at once.
  always_comb begin
    bus.o_req_ready = (state_q == IDLE);
    bus.o_rsp_valid = (state_q == RESP);
    bus.o_rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    bus.o_rsp_err   = (state_q == RESP) ? err_q : 1'b0;
    bus.o_stall     = ((state_q == IDLE) && bus.i_req_valid) || (state_q == ACCESS);
    bus.o_mem_ce    = CHIP_DISABLE;
    bus.o_mem_we    = WRITE_DISABLE;
    bus.o_mem_sel   = 4'b0000;
    bus.o_mem_addr  = '0;
    bus.o_mem_data  = '0;
    if (state_q == ACCESS) begin
      bus.o_mem_ce   = CHIP_ENABLE;
      bus.o_mem_we   = is_store(op_q) ? WRITE_ENABLE : WRITE_DISABLE;
      bus.o_mem_sel  = sel_w;
      bus.o_mem_addr = addr_q;
      bus.o_mem_data = wdat_w;
    end
  end
endmodule
